// File: rtl/board_ram_pkg.sv
// Shared constants for the board RAM: arbitration modes, client slots and
// the geometry of the Game-of-Life cell array.
package board_ram_pkg;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  localparam int CLIENT_SD   = 0;
  localparam int CLIENT_LIFE = 1;
  localparam int CLIENT_VIEW = 2;

  localparam int BOARD_CELLS  = 786432;
  localparam int BOARD_ADDR_W = 24;

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational picker: first requester found scanning from start (wrapping),
// or from index 0 when fixed priority is selected.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic             fixed,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] pos;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = fixed ? SUM_W'(k) : {1'b0, start} + SUM_W'(k);
      if (pos >= SUM_W'(N)) pos = pos - SUM_W'(N);
      if (!found && req[pos[IDX_W-1:0]]) begin
        found                = 1'b1;
        gnt[pos[IDX_W-1:0]]  = 1'b1;
        idx                  = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// N-client arbiter time-sharing the single-port board RAM: request/grant per
// client, round-robin or fixed priority, burst lock and tagged read returns.
module ram_port_arbiter
  import board_ram_pkg::*;
#(
  parameter int N_CLIENTS     = 3,
  parameter int ADDR_W        = BOARD_ADDR_W,
  parameter int DATA_W        = 1,
  parameter int RD_LATENCY    = 1,
  parameter int PRIORITY_MODE = PRIO_RR
) (
  input  logic                        clk_ram,
  input  logic                        reset_n,
  input  logic [N_CLIENTS-1:0]        req,
  input  logic [N_CLIENTS-1:0]        we,
  input  logic [N_CLIENTS-1:0]        lock,
  input  logic [N_CLIENTS*ADDR_W-1:0] addr,
  input  logic [N_CLIENTS*DATA_W-1:0] wdata,
  output logic [N_CLIENTS-1:0]        gnt,
  output logic [N_CLIENTS-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           ram_address,
  output logic [DATA_W-1:0]           ram_data,
  output logic                        ram_rden,
  output logic                        ram_wren,
  input  logic [DATA_W-1:0]           ram_q
);

  localparam int               IDX_W      = $clog2(N_CLIENTS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_CLIENTS - 1);
  localparam logic             FIXED_MODE = (PRIORITY_MODE == PRIO_FIXED);

  logic [ADDR_W-1:0]    addr_arr  [N_CLIENTS];
  logic [DATA_W-1:0]    wdata_arr [N_CLIENTS];

  logic [IDX_W-1:0]     last;
  logic [IDX_W-1:0]     last_inc;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cmd_id;
  logic [N_CLIENTS-1:0] pick_gnt;
  logic [N_CLIENTS-1:0] win_gnt;
  logic                 pick_found;
  logic                 win_found;
  logic                 lock_hit;

  logic [RD_LATENCY-1:0] tag_valid;
  logic [IDX_W-1:0]      tag_id [RD_LATENCY];

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_unpack
    assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
  end

  assign last_inc = (last == LAST_IDX) ? '0 : last + IDX_W'(1);

  // A held lock only survives while its owner keeps requesting.
  assign lock_hit = lock[last] & req[last];

  rr_pick #(
    .N     (N_CLIENTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .start (last_inc),
    .fixed (FIXED_MODE),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    win_gnt   = pick_gnt;
    win_idx   = pick_idx;
    win_found = pick_found;
    if (lock_hit) begin
      win_gnt          = '0;
      win_gnt[last]    = 1'b1;
      win_idx          = last;
      win_found        = 1'b1;
    end
  end

  assign gnt = reset_n ? win_gnt : '0;

  // Command register: one RAM access per granted cycle, enables idle otherwise.
  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      last        <= LAST_IDX;
      cmd_id      <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_rden    <= 1'b0;
      ram_wren    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values regardless of statement order.
      ram_rden <= 1'b0;
      ram_wren <= 1'b0;
      if (win_found) begin
        last        <= win_idx;
        cmd_id      <= win_idx;
        ram_address <= addr_arr[win_idx];
        ram_data    <= wdata_arr[win_idx];
        ram_wren    <= we[win_idx];
        ram_rden    <= ~we[win_idx];
      end
    end
  end

  // Tag pipeline follows the RAM's read latency, one stage per cycle.
  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the ids are reset along with the valid bits even though they
      // are only meaningful when valid; it keeps the pipe free of X on wake.
      tag_valid <= '0;
      for (int i = 0; i < RD_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      tag_valid[0] <= ram_rden;
      tag_id[0]    <= cmd_id;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    if (tag_valid[RD_LATENCY-1]) rvalid[tag_id[RD_LATENCY-1]] = 1'b1;
  end

  assign rdata = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench: three arbiter instances (round-robin, fixed, 3-cycle RAM)
// share one stimulus set, each with its own behavioural single-port RAM.
module tb_ram_port_arbiter;
  import board_ram_pkg::*;

  logic        clk_ram = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req     = '0;
  logic [2:0]  we      = '0;
  logic [2:0]  lock    = '0;
  logic [71:0] addr    = '0;
  logic [2:0]  wdata   = '0;

  logic [2:0]  gnt_o         [3];
  logic [2:0]  rvalid_o      [3];
  logic        rdata_o       [3];
  logic [23:0] ram_address_o [3];
  logic        ram_data_o    [3];
  logic        ram_rden_o    [3];
  logic        ram_wren_o    [3];
  logic        ram_q_i       [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_ram = ~clk_ram;

  // Power-up image of the board; cells 0,1,2 hold 1,0,1 and 0x0BFFFF holds 1.
  function automatic bit init_bit(input logic [23:0] a);
    return ~(a[0] ^ a[19]);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT  = (g == 2) ? 3 : 1;
    localparam int MODE = (g == 1) ? PRIO_FIXED : PRIO_RR;

    bit   written [BOARD_CELLS];
    bit   wval    [BOARD_CELLS];
    logic q_pipe  [LAT];

    ram_port_arbiter #(
      .N_CLIENTS     (3),
      .ADDR_W        (24),
      .DATA_W        (1),
      .RD_LATENCY    (LAT),
      .PRIORITY_MODE (MODE)
    ) u_dut (
      .clk_ram     (clk_ram),
      .reset_n     (reset_n),
      .req         (req),
      .we          (we),
      .lock        (lock),
      .addr        (addr),
      .wdata       (wdata),
      .gnt         (gnt_o[g]),
      .rvalid      (rvalid_o[g]),
      .rdata       (rdata_o[g]),
      .ram_address (ram_address_o[g]),
      .ram_data    (ram_data_o[g]),
      .ram_rden    (ram_rden_o[g]),
      .ram_wren    (ram_wren_o[g]),
      .ram_q       (ram_q_i[g])
    );

    always @(posedge clk_ram) begin
      if (ram_wren_o[g] && ram_address_o[g] < 24'(BOARD_CELLS)) begin
        written[int'(ram_address_o[g])] <= 1'b1;
        wval[int'(ram_address_o[g])]    <= ram_data_o[g];
      end
      if (ram_rden_o[g] && ram_address_o[g] < 24'(BOARD_CELLS))
        q_pipe[0] <= written[int'(ram_address_o[g])] ? wval[int'(ram_address_o[g])]
                                                      : init_bit(ram_address_o[g]);
      for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end

    assign ram_q_i[g] = q_pipe[LAT-1];
  end

  task automatic step();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic set_addr(input int c, input logic [23:0] a);
    addr[c*24 +: 24] = a;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk_ram);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = 3'b111; lock = 3'b111; we = '0;
    @(negedge clk_ram);
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (gnt_o[g] !== 3'b000) begin
        miscompares++; $display("FAIL reset gnt inst %0d: got %b want 000", g, gnt_o[g]);
      end
      vectors++;
      if (rvalid_o[g] !== 3'b000) begin
        miscompares++; $display("FAIL reset rvalid inst %0d: got %b want 000", g, rvalid_o[g]);
      end
      vectors++;
      if ({ram_rden_o[g], ram_wren_o[g], ram_data_o[g], ram_address_o[g]} !== 27'd0) begin
        miscompares++;
        $display("FAIL reset ram outputs inst %0d: got rden=%b wren=%b data=%b addr=%h want all 0",
                 g, ram_rden_o[g], ram_wren_o[g], ram_data_o[g], ram_address_o[g]);
      end
    end
    @(posedge clk_ram);
    #1 reset_n = 1'b1;
    lock = '0;
    @(negedge clk_ram);
    for (int g = 0; g < 3; g++) begin
      vectors++;
      if (gnt_o[g] !== 3'b001) begin
        miscompares++; $display("FAIL first grant inst %0d: got %b want 001", g, gnt_o[g]);
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [2:0] gnt_exp [6];
    logic [2:0] rv_exp  [6];
    logic       rd_exp  [6];
    gnt_exp = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000};
    rv_exp  = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
    rd_exp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      req = (c < 3) ? 3'b010 : 3'b000;
      we  = 3'b000;
      set_addr(CLIENT_LIFE, 24'(c));
      @(negedge clk_ram);
      vectors++;
      if (gnt_o[0] !== gnt_exp[c]) begin
        miscompares++; $display("FAIL b2b gnt cycle %0d: got %b want %b", c, gnt_o[0], gnt_exp[c]);
      end
      vectors++;
      if (rvalid_o[0] !== rv_exp[c]) begin
        miscompares++; $display("FAIL b2b rvalid cycle %0d: got %b want %b", c, rvalid_o[0], rv_exp[c]);
      end
      if (rv_exp[c] != 3'b000) begin
        vectors++;
        if (rdata_o[0] !== rd_exp[c]) begin
          miscompares++; $display("FAIL b2b rdata cycle %0d: got %b want %b", c, rdata_o[0], rd_exp[c]);
        end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] gnt_exp  [6];
    logic       rden_exp [6];
    logic       wren_exp [6];
    gnt_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rden_exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    wren_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    req = 3'b111; we = 3'b010; wdata = 3'b010;
    set_addr(CLIENT_SD,   24'h000300);
    set_addr(CLIENT_LIFE, 24'h000200);
    set_addr(CLIENT_VIEW, 24'h000400);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_ram);
      vectors++;
      if (gnt_o[0] !== gnt_exp[c]) begin
        miscompares++; $display("FAIL rr gnt cycle %0d: got %b want %b", c, gnt_o[0], gnt_exp[c]);
      end
      vectors++;
      if (ram_rden_o[0] !== rden_exp[c] || ram_wren_o[0] !== wren_exp[c]) begin
        miscompares++;
        $display("FAIL rr enables cycle %0d: got rden=%b wren=%b want rden=%b wren=%b",
                 c, ram_rden_o[0], ram_wren_o[0], rden_exp[c], wren_exp[c]);
      end
      vectors++;
      if ((ram_rden_o[0] & ram_wren_o[0]) !== 1'b0) begin
        miscompares++; $display("FAIL rr exclusive enables cycle %0d: got both high want at most one", c);
      end
      step();
    end
  endtask

  task automatic test_fixed();
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      logic [2:0] gnt_exp;
      req     = (c < 4) ? 3'b111 : (c < 6) ? 3'b110 : 3'b100;
      gnt_exp = (c < 4) ? 3'b001 : (c < 6) ? 3'b010 : 3'b100;
      @(negedge clk_ram);
      vectors++;
      if (gnt_o[1] !== gnt_exp) begin
        miscompares++; $display("FAIL fixed gnt cycle %0d: got %b want %b", c, gnt_o[1], gnt_exp);
      end
      step();
    end
  endtask

  task automatic test_lock();
    logic [7:0] wpat = 8'b1100_1010;
    apply_reset();
    for (int c = 0; c < 13; c++) begin
      logic [2:0] gnt_exp;
      logic [2:0] rv_exp;
      if (c < 8) begin
        req = 3'b101; lock = 3'b001; we = 3'b001;
        set_addr(CLIENT_SD, 24'h000100 + 24'(c));
        set_addr(CLIENT_VIEW, 24'h000050);
        wdata[0] = wpat[c];
      end else if (c == 8) begin
        req = 3'b100;
      end else if (c == 9) begin
        req = 3'b001; lock = 3'b000; we = 3'b000;
        set_addr(CLIENT_SD, 24'h000103);
      end else begin
        req = 3'b000;
      end
      gnt_exp = (c < 8) ? 3'b001 : (c == 8) ? 3'b100 : (c == 9) ? 3'b001 : 3'b000;
      rv_exp  = (c == 10) ? 3'b100 : (c == 11) ? 3'b001 : 3'b000;
      @(negedge clk_ram);
      vectors++;
      if (gnt_o[0] !== gnt_exp) begin
        miscompares++; $display("FAIL lock gnt cycle %0d: got %b want %b", c, gnt_o[0], gnt_exp);
      end
      if (c >= 1 && c <= 8) begin
        vectors++;
        if (ram_wren_o[0] !== 1'b1 || ram_address_o[0] !== 24'h000100 + 24'(c - 1) ||
            ram_data_o[0] !== wpat[c-1]) begin
          miscompares++;
          $display("FAIL lock write cmd cycle %0d: got wren=%b addr=%h data=%b want wren=1 addr=%h data=%b",
                   c, ram_wren_o[0], ram_address_o[0], ram_data_o[0], 24'h000100 + 24'(c - 1), wpat[c-1]);
        end
      end
      vectors++;
      if (rvalid_o[0] !== rv_exp) begin
        miscompares++; $display("FAIL lock rvalid cycle %0d: got %b want %b", c, rvalid_o[0], rv_exp);
      end
      if (rv_exp != 3'b000) begin
        vectors++;
        if (rdata_o[0] !== 1'b1) begin
          miscompares++; $display("FAIL lock rdata cycle %0d: got %b want 1", c, rdata_o[0]);
        end
      end
      step();
    end
  endtask

  task automatic test_latency3();
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      logic [2:0] gnt_exp;
      logic [2:0] rv_exp;
      req = (c == 0) ? 3'b100 : 3'b000;
      we  = 3'b000;
      set_addr(CLIENT_VIEW, 24'h0BFFFF);
      gnt_exp = (c == 0) ? 3'b100 : 3'b000;
      rv_exp  = (c == 4) ? 3'b100 : 3'b000;
      @(negedge clk_ram);
      vectors++;
      if (gnt_o[2] !== gnt_exp) begin
        miscompares++; $display("FAIL lat3 gnt cycle %0d: got %b want %b", c, gnt_o[2], gnt_exp);
      end
      vectors++;
      if (rvalid_o[2] !== rv_exp) begin
        miscompares++; $display("FAIL lat3 rvalid cycle %0d: got %b want %b", c, rvalid_o[2], rv_exp);
      end
      if (rv_exp != 3'b000) begin
        vectors++;
        if (rdata_o[2] !== 1'b1) begin
          miscompares++; $display("FAIL lat3 rdata cycle %0d: got %b want 1", c, rdata_o[2]);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_inflight();
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      logic [2:0] gnt_exp;
      logic [2:0] rv_exp;
      we = 3'b000;
      case (c)
        0:       begin req = 3'b010; set_addr(CLIENT_LIFE, 24'h000000); end
        1:       begin req = 3'b010; set_addr(CLIENT_LIFE, 24'h000002); end
        2:       begin req = 3'b000; reset_n = 1'b0; end
        3, 4:    req = 3'b111;
        5:       begin req = 3'b111; reset_n = 1'b1; end
        default: req = 3'b000;
      endcase
      gnt_exp = (c < 2) ? 3'b010 : (c == 5) ? 3'b001 : 3'b000;
      rv_exp  = (c == 7) ? 3'b001 : 3'b000;
      @(negedge clk_ram);
      vectors++;
      if (gnt_o[0] !== gnt_exp) begin
        miscompares++; $display("FAIL inflight gnt cycle %0d: got %b want %b", c, gnt_o[0], gnt_exp);
      end
      vectors++;
      if (rvalid_o[0] !== rv_exp) begin
        miscompares++; $display("FAIL inflight rvalid cycle %0d: got %b want %b", c, rvalid_o[0], rv_exp);
      end
      if (c >= 2 && c <= 4) begin
        vectors++;
        if ({ram_rden_o[0], ram_wren_o[0], ram_data_o[0], ram_address_o[0]} !== 27'd0) begin
          miscompares++;
          $display("FAIL inflight ram outputs cycle %0d: got rden=%b wren=%b data=%b addr=%h want all 0",
                   c, ram_rden_o[0], ram_wren_o[0], ram_data_o[0], ram_address_o[0]);
        end
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_round_robin();
    test_fixed();
    test_lock();
    test_latency3();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
